// File: rtl/adder_pipe_nbit_if.sv
// Streaming handshake bundle for adder_pipe_nbit: operand side (a/b/carry_in with
// in_valid/in_ready) and result side (sum/overflow with out_valid/out_ready).
interface adder_pipe_nbit_if #(
  parameter int NUM_BITS = 16
);

  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;
  logic                out_valid;
  logic                out_ready;

  // The master is the surrounding datapath: it produces operands and consumes results.
  modport master (
    output a, b, carry_in, in_valid, out_ready,
    input  in_ready, sum, overflow, out_valid
  );

  modport slave (
    input  a, b, carry_in, in_valid, out_ready,
    output in_ready, sum, overflow, out_valid
  );

endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined NUM_BITS unsigned adder, one W-bit carry-chained slice per stage.
// Optional macro ADDER_SAT_EN: clamp the sum to all ones when the final carry is set.
module adder_pipe_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4
) (
  input logic              clk,
  input logic              n_rst,
  adder_pipe_nbit_if.slave bus
);

  localparam int W = NUM_BITS / NUM_STAGES;

  logic                  advance;

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] carry_q;
  logic [NUM_STAGES-1:0] carry_d;
  logic [NUM_BITS-1:0]   opA_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   opB_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   sum_q [NUM_STAGES];
  logic [NUM_BITS-1:0]   sum_d [NUM_STAGES];

  logic [NUM_STAGES-1:0] validIn;
  logic [NUM_STAGES-1:0] carryIn;
  logic [NUM_BITS-1:0]   aIn   [NUM_STAGES];
  logic [NUM_BITS-1:0]   bIn   [NUM_STAGES];
  logic [NUM_BITS-1:0]   sumIn [NUM_STAGES];

  // The whole pipe moves as one; a stalled consumer freezes every stage, bubbles included.
  assign advance      = bus.out_ready || !valid_q[NUM_STAGES-1];
  assign bus.in_ready = advance;

  assign bus.sum       = sum_q[NUM_STAGES-1];
  assign bus.overflow  = carry_q[NUM_STAGES-1];
  assign bus.out_valid = valid_q[NUM_STAGES-1];

  always_comb begin : stageInputs
    aIn[0]     = bus.a;
    bIn[0]     = bus.b;
    sumIn[0]   = '0;
    carryIn[0] = bus.carry_in;
    validIn[0] = bus.in_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      aIn[k]     = opA_q[k-1];
      bIn[k]     = opB_q[k-1];
      sumIn[k]   = sum_q[k-1];
      carryIn[k] = carry_q[k-1];
      validIn[k] = valid_q[k-1];
    end
  end

  // Stage k adds slice k of its skewed operands and merges it into the partial sum
  // carried along from the lower stages, so all slices of one result leave together.
  always_comb begin : sliceAdders
    logic [W:0] slice;
    slice   = '0;
    carry_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      slice = {1'b0, aIn[k][k*W +: W]} + {1'b0, bIn[k][k*W +: W]} + {{W{1'b0}}, carryIn[k]};
      sum_d[k]           = sumIn[k];
      sum_d[k][k*W +: W] = slice[W-1:0];
      carry_d[k]         = slice[W];
    end
`ifdef ADDER_SAT_EN
    if (carry_d[NUM_STAGES-1]) begin
      sum_d[NUM_STAGES-1] = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        opA_q[k] <= '0;
        opB_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= validIn;
      carry_q <= carry_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        opA_q[k] <= aIn[k];
        opB_q[k] <= bIn[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed self-checking bench for adder_pipe_nbit (16 bits, 4 stages); define
// ADDER_SAT_EN for both bench and RTL to check the saturating build.
module tb_adder_pipe_nbit;

`ifdef ADDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] expSum;
    logic        expOvf;
  } vector_t;

  logic clk;
  logic n_rst;
  int   testsRun;
  int   testsFailed;

  vector_t     vectors [9];
  logic [15:0] beatA [8];
  logic [15:0] beatB [8];
  logic        beatC [8];
  logic [16:0] expRes;

  adder_pipe_nbit_if #(.NUM_BITS(16)) bus ();

  adder_pipe_nbit #(
    .NUM_BITS  (16),
    .NUM_STAGES(4)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] r;
    r = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    if (r[16] && SAT_EN) r[15:0] = 16'hFFFF;
    return r;
  endfunction

  function automatic logic [15:0] satAdjust(input logic [15:0] s, input logic ovf);
    logic [15:0] r;
    r = s;
    if (ovf && SAT_EN) r = 16'hFFFF;
    return r;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic outReady);
    bus.in_valid  = valid;
    bus.a         = a;
    bus.b         = b;
    bus.carry_in  = cin;
    bus.out_ready = outReady;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vectors[0] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vectors[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vectors[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vectors[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vectors[4] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0};
    vectors[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vectors[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vectors[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vectors[8] = '{16'hF0F0, 16'h0F10, 1'b0, 16'h0000, 1'b1};

    // Reset state
    n_rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    #12;
    checkOutput("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("reset sum", {16'b0, bus.sum}, 32'd0);
    checkOutput("reset overflow", {31'b0, bus.overflow}, 32'd0);
    #10;
    n_rst = 1'b1;
    #1;
    checkOutput("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    nextCycle();

    // Single beats from the table: out_valid exactly in cycle 4, then gone
    for (int v = 0; v < 9; v++) begin
      for (int cyc = 0; cyc < 6; cyc++) begin
        if (cyc == 0) applyStimulus(1'b1, vectors[v].a, vectors[v].b, vectors[v].cin, 1'b1);
        else          applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput($sformatf("vec%0d out_valid cyc%0d", v, cyc), {31'b0, bus.out_valid},
                    {31'b0, cyc == 4});
        if (cyc == 4) begin
          checkOutput($sformatf("vec%0d sum", v), {16'b0, bus.sum},
                      {16'b0, satAdjust(vectors[v].expSum, vectors[v].expOvf)});
          checkOutput($sformatf("vec%0d overflow", v), {31'b0, bus.overflow}, {31'b0, vectors[v].expOvf});
        end
        nextCycle();
      end
    end

    // Streaming: 8 back-to-back beats, results in cycles 4..11 without gaps
    for (int i = 0; i < 8; i++) begin
      beatA[i] = 16'(i * 16'h1111);
      beatB[i] = 16'h0101;
      beatC[i] = i[0];
    end
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 8) applyStimulus(1'b1, beatA[cyc], beatB[cyc], beatC[cyc], 1'b1);
      else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("stream out_valid cyc%0d", cyc), {31'b0, bus.out_valid},
                  {31'b0, (cyc >= 4) && (cyc < 12)});
      if ((cyc >= 4) && (cyc < 12)) begin
        expRes = refAdd(beatA[cyc-4], beatB[cyc-4], beatC[cyc-4]);
        checkOutput($sformatf("stream sum beat%0d", cyc - 4), {16'b0, bus.sum}, {16'b0, expRes[15:0]});
        checkOutput($sformatf("stream overflow beat%0d", cyc - 4), {31'b0, bus.overflow}, {31'b0, expRes[16]});
      end
      nextCycle();
    end

    // Stall: 4 beats in flight, out_ready low for cycles 4..6, ignored offer meanwhile
    beatA[0] = 16'hFFF0; beatB[0] = 16'h0020; beatC[0] = 1'b1;
    beatA[1] = 16'h0123; beatB[1] = 16'h0456; beatC[1] = 1'b0;
    beatA[2] = 16'h8888; beatB[2] = 16'h8888; beatC[2] = 1'b0;
    beatA[3] = 16'h00F0; beatB[3] = 16'h0F0F; beatC[3] = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      if (cyc < 4)      applyStimulus(1'b1, beatA[cyc], beatB[cyc], beatC[cyc], 1'b1);
      else if (cyc < 7) applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
      else              applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (cyc >= 4 && cyc < 7) begin
        expRes = refAdd(beatA[0], beatB[0], beatC[0]);
        checkOutput($sformatf("stall in_ready cyc%0d", cyc), {31'b0, bus.in_ready}, 32'd0);
        checkOutput($sformatf("stall out_valid cyc%0d", cyc), {31'b0, bus.out_valid}, 32'd1);
        checkOutput($sformatf("stall sum held cyc%0d", cyc), {16'b0, bus.sum}, {16'b0, expRes[15:0]});
        checkOutput($sformatf("stall overflow held cyc%0d", cyc), {31'b0, bus.overflow}, {31'b0, expRes[16]});
      end
      if (cyc >= 7) begin
        checkOutput($sformatf("drain out_valid cyc%0d", cyc), {31'b0, bus.out_valid},
                    {31'b0, cyc <= 10});
        if (cyc <= 10) begin
          expRes = refAdd(beatA[cyc-7], beatB[cyc-7], beatC[cyc-7]);
          checkOutput($sformatf("drain sum beat%0d", cyc - 7), {16'b0, bus.sum}, {16'b0, expRes[15:0]});
          checkOutput($sformatf("drain overflow beat%0d", cyc - 7), {31'b0, bus.overflow}, {31'b0, expRes[16]});
        end
      end
      nextCycle();
    end

    // Reset mid-flight: 3 beats in flight, the first one already at the output
    beatA[0] = 16'hFFFF; beatB[0] = 16'h0002; beatC[0] = 1'b0;
    beatA[1] = 16'h1111; beatB[1] = 16'h2222; beatC[1] = 1'b0;
    beatA[2] = 16'h4444; beatB[2] = 16'h4444; beatC[2] = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 3) applyStimulus(1'b1, beatA[cyc], beatB[cyc], beatC[cyc], 1'b1);
      else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      if (cyc < 4) nextCycle();
    end
    @(negedge clk);
    expRes = refAdd(beatA[0], beatB[0], beatC[0]);
    checkOutput("pre-reset out_valid", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("pre-reset sum", {16'b0, bus.sum}, {16'b0, expRes[15:0]});
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("mid reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("mid reset sum", {16'b0, bus.sum}, 32'd0);
    checkOutput("mid reset overflow", {31'b0, bus.overflow}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    nextCycle();
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
      else          applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("after reset out_valid cyc%0d", cyc), {31'b0, bus.out_valid},
                  {31'b0, cyc == 4});
      if (cyc == 4) begin
        checkOutput("after reset sum", {16'b0, bus.sum}, 32'h0003);
        checkOutput("after reset overflow", {31'b0, bus.overflow}, 32'd0);
      end
      nextCycle();
    end

    // Bubbles: in_valid 1/0 alternating for 6 cycles, results in cycles 4, 6, 8
    for (int i = 0; i < 6; i++) begin
      beatA[i] = 16'(16'h2001 * (i + 1));
      beatB[i] = 16'h7777;
      beatC[i] = i[1];
    end
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc < 6) applyStimulus(cyc % 2 == 0, beatA[cyc], beatB[cyc], beatC[cyc], 1'b1);
      else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("bubble out_valid cyc%0d", cyc), {31'b0, bus.out_valid},
                  {31'b0, (cyc == 4) || (cyc == 6) || (cyc == 8)});
      if ((cyc == 4) || (cyc == 6) || (cyc == 8)) begin
        expRes = refAdd(beatA[cyc-4], beatB[cyc-4], beatC[cyc-4]);
        checkOutput($sformatf("bubble sum cyc%0d", cyc), {16'b0, bus.sum}, {16'b0, expRes[15:0]});
        checkOutput($sformatf("bubble overflow cyc%0d", cyc), {31'b0, bus.overflow}, {31'b0, expRes[16]});
      end
      nextCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
